ppu_bus_decoder: RTL and testbench
==================================

Name: ppu_bus_decoder

Overview:
- Sits directly downstream of the PPU's multiplexed memory bus (PPU_AD, ALE, RD, WR).
- Performs the external address-latch function: demultiplexes the bus into a 14-bit address and decodes it into CHR space (0x0000-0x1FFF) and nametable space (0x2000-0x3EFF).
- Serves nametable accesses from internal 2 KB RAM with runtime-selectable mirroring, and returns read data onto PPU_AD[7:0].
- Clocked by the same master clock as the PPU, so no synchronisers are needed.

Parameters:
- NT_BYTES, 2048: internal nametable RAM depth; must be a power of two, at least 2048.
- CHR_BYTES, 8192: CHR space size; sets the CHR RAM depth when CHR_RAM_EN is defined.

Ports:
- CLK  input  1  master clock.
- RST  input  1  asynchronous reset, active-low.
- AD_IN  input  14  PPU_AD as seen on the bus.
- AD_OUT  output  8  read data to drive onto PPU_AD[7:0].
- AD_OE  output  1  high = drive AD_OUT onto the bus.
- ALE  input  1  address latch enable, active-high.
- RD  input  1  read strobe, active-low.
- WR  input  1  write strobe, active-low.
- MIRROR  input  1  0 = horizontal mirroring, 1 = vertical mirroring.
- chr_addr  output  13  CHR ROM address.
- chr_rd_data  input  8  CHR ROM data, valid 1 cycle after chr_addr.
- bus_conflict  output  1  sticky error flag.
- addr_dbg  output  14  currently latched address (for the HEX displays).

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE; AD_OE = 0; AD_OUT = 0x00; latched address = 0; chr_addr = 0; bus_conflict = 0.
  - RAM contents are not cleared.
- Address latch:
  - Every cycle ALE = 1: lo <= AD_IN[7:0] and hi <= AD_IN[13:8].
  - ADDR = {hi, lo}, held while ALE = 0. addr_dbg = ADDR.
- Edge detection: RD and WR are registered once per cycle. A "fall" is prev = 1 and current = 0; a "rise" is prev = 0 and current = 1.
- Decode:
  - ADDR[13] = 0: CHR.
  - ADDR[13] = 1 and ADDR[13:8] < 0x3F: NT. The 0x3000-0x3EFF range aliases 0x2000-0x2EFF.
  - ADDR >= 0x3F00: NONE (palette lives inside the PPU). NONE is never driven and never written.
- Nametable RAM index = {MIRROR ? ADDR[10] : ADDR[11], ADDR[9:0]}. MIRROR is sampled at the access start.
- State machine, IDLE → RD_WAIT → RD_DRIVE → IDLE, plus IDLE → WR_HOLD → IDLE:
  - IDLE:
    - RD fall and ALE = 0 → RD_WAIT. Issue the RAM read, or set chr_addr = ADDR[12:0].
    - Else WR fall and ALE = 0 → WR_HOLD.
  - RD_WAIT (1 cycle) → RD_DRIVE:
    - AD_OUT <= RAM/CHR data, or 0x00 for NONE.
    - AD_OE <= 1 unless region is NONE.
    - Read latency: AD_OE goes high 2 cycles after RD is sampled low.
  - RD_DRIVE:
    - Hold AD_OUT/AD_OE.
    - RD rise → IDLE with AD_OE <= 0 on the same edge.
  - WR_HOLD:
    - Each cycle, wdata <= AD_IN[7:0].
    - On WR rise, write wdata (last value sampled while WR was low) to the decoded target, then → IDLE.
    - CHR writes are ignored without CHR_RAM_EN.
- Boundary conditions:
  - RD fall and WR fall in the same cycle: RD wins, the write is dropped, bus_conflict <= 1.
  - RD or WR fall while ALE = 1: ignored, bus_conflict <= 1.
  - ALE = 1 while in RD_DRIVE/RD_WAIT/WR_HOLD: abort → IDLE, AD_OE <= 0, no write, bus_conflict <= 1.
  - bus_conflict clears only on reset.
  - RD/WR low after reset deassertion (no fall seen): no access until a fresh fall.
  - Address wrap: 0x3EFF decodes to NT; 0x3F00 decodes to NONE; 0x1FFF decodes to CHR.

Optional Feature:
- Macro CHR_RAM_EN.
- Defined:
  - The CHR region uses internal CHR_BYTES RAM, readable and writable with the same timing as NT.
  - chr_addr is held at 0; chr_rd_data is ignored.
- Undefined:
  - CHR reads use chr_addr/chr_rd_data (external ROM).
  - CHR writes complete their handshake but change nothing.

Test Plan:
- Reset, then WR 0x2005 ← 0xA7 (MIRROR = 1), then RD 0x2805 → AD_OE high 2 cycles after RD low, AD_OUT = 0xA7; RD 0x2405 ≠ 0xA7-location (different bank).
- MIRROR = 0: write 0x2010 ← 0x3C, then read 0x2410 → 0x3C; read 0x3010 → 0x3C (alias).
- CHR read 0x1ABC, ROM model returns 0x5E one cycle later → chr_addr = 0x1ABC, AD_OUT = 0x5E; with CHR_RAM_EN: write 0x0100 ← 0x99 then read → 0x99.
- Read 0x3F00 → AD_OE stays 0 throughout; write 0x3F10 ← 0xFF → subsequent read 0x2F10 unchanged.
- RD and WR fall in the same cycle at 0x2000 → read proceeds, RAM unchanged, bus_conflict = 1 until RST pulse.
- Assert RST low during RD_DRIVE → AD_OE = 0 immediately (asynchronous); after release, RD still low → no drive until the next RD fall.

Source files
------------

// File: rtl/ppu_bus_decoder.sv
// ppu_bus_decoder: external address latch and nametable/CHR decoder for the PPU bus.
// Demultiplexes PPU_AD into a 14-bit address. Serves nametable reads and writes from
// internal RAM with selectable mirroring. Sends CHR reads to an external ROM port.
// Optional build macro CHR_RAM_EN: the CHR region is served from internal RAM
// instead of the external ROM.
module ppu_bus_decoder #(
  parameter int NT_BYTES  = 2048,
  parameter int CHR_BYTES = 8192
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [13:0] AD_IN,
  output logic [7:0]  AD_OUT,
  output logic        AD_OE,
  input  logic        ALE,
  input  logic        RD,
  input  logic        WR,
  input  logic        MIRROR,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_rd_data,
  output logic        bus_conflict,
  output logic [13:0] addr_dbg
);

  localparam int NT_AW  = $clog2(NT_BYTES);
  localparam int CHR_AW = $clog2(CHR_BYTES);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;
  typedef enum logic [1:0] {REG_CHR, REG_NT, REG_NONE} region_t;

  state_t             state_q;
  region_t            region_q, region_d;
  logic [13:0]        addr_q;
  logic               rd_q, rdPrev_q, wr_q, wrPrev_q;
  logic [7:0]         adDly_q, wdata_q, adOut_q, ntRd_q, readData;
  logic               adOe_q, conflict_q;
  logic [12:0]        chrAddr_q;
  logic [NT_AW-1:0]   ntIdx_q, ntIdx_d;
  logic               rdFall, rdRise, wrFall, wrRise;
  logic               startRd, commitWr;

  logic [7:0] ntRam [NT_BYTES];

`ifdef CHR_RAM_EN
  logic [7:0] chrRam [CHR_BYTES];
  logic [7:0] chrRd_q;
`endif

  assign rdFall   = rdPrev_q & ~rd_q;
  assign rdRise   = ~rdPrev_q & rd_q;
  assign wrFall   = wrPrev_q & ~wr_q;
  assign wrRise   = ~wrPrev_q & wr_q;
  assign startRd  = (state_q == IDLE) && rdFall && !ALE;
  assign commitWr = (state_q == WR_HOLD) && !ALE && wrRise;
  assign ntIdx_d  = NT_AW'({MIRROR ? addr_q[10] : addr_q[11], addr_q[9:0]});

  assign AD_OUT       = adOut_q;
  assign AD_OE        = adOe_q;
  assign chr_addr     = chrAddr_q;
  assign bus_conflict = conflict_q;
  assign addr_dbg     = addr_q;

  // Classify the latched address; everything from 0x3F00 up belongs to the PPU palette.
  always_comb begin
    region_d = REG_NONE;
    if (!addr_q[13]) begin
      region_d = REG_CHR;
    end else if (addr_q[13:8] < 6'h3F) begin
      region_d = REG_NT;
    end
  end

  // Pick the byte that the RD_WAIT cycle loads into the output register.
  always_comb begin
    readData = 8'h00;
    case (region_q)
      REG_NT:  readData = ntRd_q;
`ifdef CHR_RAM_EN
      REG_CHR: readData = chrRd_q;
`else
      REG_CHR: readData = chr_rd_data;
`endif
      default: readData = 8'h00;
    endcase
  end

  // Address latch follows AD_IN while ALE is high. The strobe pipeline resets low,
  // so a strobe that is already low when reset releases never shows up as a fall.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q   <= 14'h0000;
      rd_q     <= 1'b0;
      rdPrev_q <= 1'b0;
      wr_q     <= 1'b0;
      wrPrev_q <= 1'b0;
      adDly_q  <= 8'h00;
    end else begin
      if (ALE) begin
        addr_q <= AD_IN;
      end
      rd_q     <= RD;
      rdPrev_q <= rd_q;
      wr_q     <= WR;
      wrPrev_q <= wr_q;
      adDly_q  <= AD_IN[7:0];
    end
  end

  // Nametable RAM: synchronous read at access start, write on the WR rise.
  always_ff @(posedge CLK) begin
    if (commitWr && region_q == REG_NT) begin
      ntRam[ntIdx_q] <= wdata_q;
    end
    if (startRd && region_d == REG_NT) begin
      ntRd_q <= ntRam[ntIdx_d];
    end
  end

`ifdef CHR_RAM_EN
  // CHR RAM: same timing as the nametable RAM. The address stays latched for the whole access.
  always_ff @(posedge CLK) begin
    if (commitWr && region_q == REG_CHR) begin
      chrRam[CHR_AW'(addr_q[12:0])] <= wdata_q;
    end
    if (startRd && region_d == REG_CHR) begin
      chrRd_q <= chrRam[CHR_AW'(addr_q[12:0])];
    end
  end
`endif

  // Access sequencer. Any ALE during an access aborts it and raises the sticky conflict flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      region_q   <= REG_NONE;
      ntIdx_q    <= '0;
      wdata_q    <= 8'h00;
      adOut_q    <= 8'h00;
      adOe_q     <= 1'b0;
      chrAddr_q  <= 13'h0000;
      conflict_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((rdFall || wrFall) && ALE) begin
            conflict_q <= 1'b1;
          end else if (rdFall) begin
            state_q  <= RD_WAIT;
            region_q <= region_d;
            if (wrFall) begin
              conflict_q <= 1'b1;
            end
`ifndef CHR_RAM_EN
            if (region_d == REG_CHR) begin
              chrAddr_q <= addr_q[12:0];
            end
`endif
          end else if (wrFall) begin
            state_q  <= WR_HOLD;
            region_q <= region_d;
            ntIdx_q  <= ntIdx_d;
            wdata_q  <= adDly_q;
          end
        end
        RD_WAIT: begin
          if (ALE) begin
            state_q    <= IDLE;
            adOe_q     <= 1'b0;
            conflict_q <= 1'b1;
          end else begin
            state_q <= RD_DRIVE;
            adOut_q <= readData;
            adOe_q  <= (region_q != REG_NONE);
          end
        end
        RD_DRIVE: begin
          if (ALE) begin
            state_q    <= IDLE;
            adOe_q     <= 1'b0;
            conflict_q <= 1'b1;
          end else if (rdRise) begin
            state_q <= IDLE;
            adOe_q  <= 1'b0;
          end
        end
        WR_HOLD: begin
          if (ALE) begin
            state_q    <= IDLE;
            conflict_q <= 1'b1;
          end else if (wrRise) begin
            state_q <= IDLE;
          end else if (!wr_q) begin
            wdata_q <= adDly_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_bus_decoder.sv
// tb_ppu_bus_decoder: directed bench for ppu_bus_decoder with a behavioural memory model
// and a per-cycle monitor of the latched address, conflict flag and read drive.
module tb_ppu_bus_decoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [13:0] AD_IN;
  logic [7:0]  AD_OUT;
  logic        AD_OE;
  logic        ALE, RD, WR, MIRROR;
  logic [12:0] chr_addr;
  logic [7:0]  chr_rd_data;
  logic        bus_conflict;
  logic [13:0] addr_dbg;

  int checks   = 0;
  int failures = 0;

  logic        monEn = 1'b0;
  logic [13:0] expAddr = 14'h0;
  logic        expConflict = 1'b0;
  logic        expOe = 1'b0;
  logic [7:0]  expOut = 8'h00;

  logic [7:0]  ntModel [2048];

  ppu_bus_decoder dut (
    .CLK(CLK), .RST(RST), .AD_IN(AD_IN), .AD_OUT(AD_OUT), .AD_OE(AD_OE),
    .ALE(ALE), .RD(RD), .WR(WR), .MIRROR(MIRROR), .chr_addr(chr_addr),
    .chr_rd_data(chr_rd_data), .bus_conflict(bus_conflict), .addr_dbg(addr_dbg)
  );

  always #5 CLK = ~CLK;

  // External CHR ROM contents: one pinned byte, otherwise a simple pattern.
  function automatic logic [7:0] romByte(input logic [12:0] a);
    logic [7:0] lowByte;
    lowByte = a[7:0];
    return (a == 13'h1ABC) ? 8'h5E : (lowByte ^ 8'hA5);
  endfunction

  assign chr_rd_data = romByte(chr_addr);

  // Region of an address: 0 = CHR, 1 = nametable, 2 = palette (not served here).
  function automatic int regionOf(input int a);
    if (a < 'h2000) return 0;
    if (a < 'h3F00) return 1;
    return 2;
  endfunction

  // Horizontal mirroring pairs the 1 KB pages by the 2 KB half. Vertical mirroring pairs them by odd/even page.
  function automatic int ntIndex(input int a, input bit m);
    int bank;
    bank = m ? (a / 1024) % 2 : (a / 2048) % 2;
    return bank * 1024 + (a % 1024);
  endfunction

  function automatic logic [7:0] modelRead(input int a, input bit m);
    logic [12:0] ca;
    ca = 13'(a);
    case (regionOf(a))
      1: return ntModel[ntIndex(a, m)];
`ifdef CHR_RAM_EN
      0: return 8'h00;
`else
      0: return romByte(ca);
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelWrite(input int a, input bit m, input logic [7:0] d);
    if (regionOf(a) == 1) ntModel[ntIndex(a, m)] = d;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every cycle, compare the DUT outputs against the bench's expectations.
  always @(negedge CLK) begin
    if (monEn) begin
      checkOutput("mon_addr_dbg", addr_dbg, expAddr);
      checkOutput("mon_conflict", bus_conflict, expConflict);
      checkOutput("mon_ad_oe", AD_OE, expOe);
      if (expOe) checkOutput("mon_ad_out", AD_OUT, expOut);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic latchAddr(input logic [13:0] a);
    @(posedge CLK); #1 ALE = 1'b1; AD_IN = a;
    @(posedge CLK); #1 ALE = 1'b0; expAddr = a;
  endtask

  // One complete bus access. For a read, 'data' is the byte that must appear on AD_OUT.
  task automatic applyStimulus(input bit isWrite, input logic [13:0] a, input bit m,
                               input logic [7:0] data, input string name);
    MIRROR = m;
    latchAddr(a);
    if (isWrite) begin
      AD_IN = {6'h00, data};
      WR = 1'b0;
      repeat (3) @(posedge CLK);
      #1 WR = 1'b1;
      repeat (3) @(posedge CLK);
      #1 modelWrite(a, m, data);
      AD_IN = 14'h0;
    end else begin
      RD = 1'b0;
      repeat (2) @(posedge CLK);
      #1 checkOutput({name, "_oe_early"}, AD_OE, 0);
      @(posedge CLK);
      #1 expOe = (regionOf(a) != 2);
      expOut = data;
      checkOutput({name, "_oe"}, AD_OE, expOe);
      if (expOe) checkOutput({name, "_data"}, AD_OUT, data);
      @(posedge CLK);
      #1 RD = 1'b1;
      repeat (2) @(posedge CLK);
      #1 expOe = 1'b0;
      checkOutput({name, "_oe_release"}, AD_OE, 0);
    end
    @(posedge CLK);
  endtask

  task automatic pulseReset(input string name);
    @(posedge CLK); #1 RST = 1'b0;
    expConflict = 1'b0; expAddr = 14'h0; expOe = 1'b0;
    #2 checkOutput({name, "_conflict_cleared"}, bus_conflict, 0);
    @(posedge CLK); #1 RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0; AD_IN = 14'h0; ALE = 1'b0; RD = 1'b1; WR = 1'b1; MIRROR = 1'b0;
    repeat (3) @(posedge CLK);
    #1 checkOutput("rst_ad_oe", AD_OE, 0);
    checkOutput("rst_ad_out", AD_OUT, 0);
    checkOutput("rst_addr_dbg", addr_dbg, 0);
    checkOutput("rst_chr_addr", chr_addr, 0);
    checkOutput("rst_conflict", bus_conflict, 0);
    RST = 1'b1;
    monEn = 1'b1;
    repeat (2) @(posedge CLK);

    // Vertical mirroring: 0x2000 and 0x2800 share a bank, 0x2400 is the other one.
    applyStimulus(1, 14'h2405, 1, 8'h11, "wr_2405");
    applyStimulus(1, 14'h2005, 1, 8'hA7, "wr_2005");
    applyStimulus(0, 14'h2805, 1, 8'hA7, "rd_2805");
    applyStimulus(0, 14'h2405, 1, 8'h11, "rd_2405");

    // Horizontal mirroring plus the 0x3000 alias.
    applyStimulus(1, 14'h2010, 0, 8'h3C, "wr_2010");
    applyStimulus(0, 14'h2410, 0, 8'h3C, "rd_2410");
    applyStimulus(0, 14'h3010, 0, 8'h3C, "rd_3010");
    applyStimulus(0, 14'h2C05, 0, modelRead('h2C05, 0), "rd_2c05_model");
    applyStimulus(0, 14'h2010, 1, modelRead('h2010, 1), "rd_2010_model");

    // Palette range is never driven or written. 0x3EFF is still nametable space.
    applyStimulus(1, 14'h2F10, 0, 8'h6D, "wr_2f10");
    applyStimulus(1, 14'h3F10, 0, 8'hFF, "wr_3f10");
    applyStimulus(0, 14'h2F10, 0, 8'h6D, "rd_2f10");
    applyStimulus(0, 14'h3F00, 0, 8'h00, "rd_3f00");
    applyStimulus(1, 14'h3EFF, 0, 8'h42, "wr_3eff");
    applyStimulus(0, 14'h2EFF, 0, 8'h42, "rd_2eff");

`ifdef CHR_RAM_EN
    applyStimulus(1, 14'h0100, 0, 8'h99, "wr_chr_0100");
    applyStimulus(0, 14'h0100, 0, 8'h99, "rd_chr_0100");
    applyStimulus(1, 14'h1FFF, 0, 8'h24, "wr_chr_1fff");
    applyStimulus(0, 14'h1FFF, 0, 8'h24, "rd_chr_1fff");
    checkOutput("chr_addr_held", chr_addr, 0);
`else
    applyStimulus(0, 14'h1ABC, 0, 8'h5E, "rd_chr_1abc");
    checkOutput("chr_addr_1abc", chr_addr, 'h1ABC);
    applyStimulus(0, 14'h1FFF, 0, 8'h5A, "rd_chr_1fff");
    checkOutput("chr_addr_1fff", chr_addr, 'h1FFF);
    applyStimulus(1, 14'h1ABC, 0, 8'h00, "wr_chr_ignored");
    applyStimulus(0, 14'h1ABC, 0, modelRead('h1ABC, 0), "rd_chr_after_wr");
`endif

    // ALE during RD_DRIVE aborts the read and raises the conflict flag.
    MIRROR = 1'b0;
    latchAddr(14'h2010);
    RD = 1'b0;
    repeat (3) @(posedge CLK);
    #1 expOe = 1'b1; expOut = 8'h3C;
    checkOutput("abort_pre_oe", AD_OE, 1);
    ALE = 1'b1; AD_IN = 14'h2000;
    @(posedge CLK);
    #1 ALE = 1'b0; RD = 1'b1;
    expOe = 1'b0; expConflict = 1'b1; expAddr = 14'h2000;
    checkOutput("abort_oe", AD_OE, 0);
    checkOutput("abort_conflict", bus_conflict, 1);
    repeat (3) @(posedge CLK);
    pulseReset("after_abort");

    // RD and WR fall together: the read wins and the write is dropped.
    applyStimulus(1, 14'h2000, 0, 8'hC3, "wr_2000");
    latchAddr(14'h2000);
    AD_IN = 14'h0055; RD = 1'b0; WR = 1'b0;
    repeat (2) @(posedge CLK);
    #1 expConflict = 1'b1;
    @(posedge CLK);
    #1 expOe = 1'b1; expOut = 8'hC3;
    checkOutput("both_fall_data", AD_OUT, 'hC3);
    checkOutput("both_fall_conflict", bus_conflict, 1);
    RD = 1'b1; WR = 1'b1;
    repeat (2) @(posedge CLK);
    #1 expOe = 1'b0; AD_IN = 14'h0;
    applyStimulus(0, 14'h2000, 0, 8'hC3, "rd_2000_unchanged");
    checkOutput("conflict_sticky", bus_conflict, 1);
    pulseReset("after_both_fall");

    // Asynchronous reset during RD_DRIVE. RD still low afterwards must not start a read.
    MIRROR = 1'b1;
    latchAddr(14'h2005);
    RD = 1'b0;
    repeat (3) @(posedge CLK);
    #1 expOe = 1'b1; expOut = 8'hA7;
    checkOutput("pre_rst_oe", AD_OE, 1);
    #1 RST = 1'b0;
    expOe = 1'b0; expAddr = 14'h0; expConflict = 1'b0;
    #1 checkOutput("rst_async_oe", AD_OE, 0);
    checkOutput("rst_async_out", AD_OUT, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1 checkOutput("rd_held_no_drive", AD_OE, 0);
    RD = 1'b1;
    repeat (3) @(posedge CLK);
    applyStimulus(0, 14'h2805, 1, 8'hA7, "rd_after_rst");

    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
